// File: rtl/decode_out_queue.sv
// rtl/decode_out_queue.sv - LC-3 decode stage with a DEPTH-entry output FIFO toward execute.
// Optional perf counters (stall_cycles, flush_drops) are built when DECODE_OUT_QUEUE_PERF_EN is defined.
module decode_out_queue #(
  parameter int IR_W  = 16,
  parameter int PC_W  = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_decode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IR_W-1:0]  ir_in,
  input  logic [PC_W-1:0]  npc_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IR_W-1:0]  ir,
  output logic [PC_W-1:0]  npc_out,
  output logic [5:0]       E_control,
  output logic [1:0]       W_control,
  output logic             mem_control,
  output logic             illegal,
`ifdef DECODE_OUT_QUEUE_PERF_EN
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_drops,
`endif
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IR_W-1:0]  ir_mem  [DEPTH];
  logic [PC_W-1:0]  npc_mem [DEPTH];
  logic [5:0]       e_mem   [DEPTH];
  logic [1:0]       w_mem   [DEPTH];
  logic             m_mem   [DEPTH];
  logic             ill_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [5:0] dec_e;
  logic [1:0] dec_w;
  logic       dec_m;
  logic       dec_ill;
  logic       push;
  logic       pop;

  always_comb begin
    dec_e   = 6'b000000;
    dec_w   = 2'b00;
    dec_m   = 1'b0;
    dec_ill = 1'b0;
    case (ir_in[IR_W-1 -: 4])
      4'b0001: dec_e = {2'b00, 2'b00, 1'b0, ~ir_in[5]};
      4'b0101: dec_e = {2'b01, 2'b00, 1'b0, ~ir_in[5]};
      4'b1001: dec_e = {2'b10, 2'b00, 1'b0, 1'b0};
      4'b0000: dec_e = {2'b00, 2'b01, 1'b1, 1'b0};
      4'b1100: dec_e = {2'b00, 2'b11, 1'b0, 1'b0};
      4'b0010: begin
        dec_e = {2'b00, 2'b01, 1'b1, 1'b0};
        dec_w = 2'b10;
      end
      4'b1010: begin
        dec_e = {2'b00, 2'b01, 1'b1, 1'b0};
        dec_w = 2'b10;
        dec_m = 1'b1;
      end
      4'b0011: dec_e = {2'b00, 2'b01, 1'b1, 1'b0};
      4'b1011: begin
        dec_e = {2'b00, 2'b01, 1'b1, 1'b0};
        dec_m = 1'b1;
      end
      4'b0110: begin
        dec_e = {2'b00, 2'b10, 1'b0, 1'b0};
        dec_w = 2'b10;
      end
      4'b0111: dec_e = {2'b00, 2'b10, 1'b0, 1'b0};
      4'b1110: begin
        dec_e = {2'b00, 2'b01, 1'b1, 1'b0};
        dec_w = 2'b01;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Full blocks input even when the head is leaving this cycle: no pass-through.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & enable_decode;
  assign pop       = out_valid & out_ready;

  assign ir          = ir_mem[rd_ptr];
  assign npc_out     = npc_mem[rd_ptr];
  assign E_control   = e_mem[rd_ptr];
  assign W_control   = w_mem[rd_ptr];
  assign mem_control = m_mem[rd_ptr];
  assign illegal     = ill_mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem[i]  <= '0;
        npc_mem[i] <= '0;
        e_mem[i]   <= '0;
        w_mem[i]   <= '0;
        m_mem[i]   <= 1'b0;
        ill_mem[i] <= 1'b0;
      end
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        ir_mem[wr_ptr]  <= ir_in;
        npc_mem[wr_ptr] <= npc_in;
        e_mem[wr_ptr]   <= dec_e;
        w_mem[wr_ptr]   <= dec_w;
        m_mem[wr_ptr]   <= dec_m;
        ill_mem[wr_ptr] <= dec_ill;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef DECODE_OUT_QUEUE_PERF_EN
  logic [16:0] drops_sum;
  assign drops_sum = {1'b0, flush_drops} + 17'(count);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_drops  <= '0;
    end else begin
      if (in_valid && enable_decode && !in_ready && stall_cycles != 16'hFFFF) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (flush) begin
        flush_drops <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_decode_out_queue.sv
// tb/tb_decode_out_queue.sv - directed self-checking bench for decode_out_queue (DEPTH=2).
module tb_decode_out_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_decode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ir_in;
  logic [15:0] npc_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ir;
  logic [15:0] npc_out;
  logic [5:0]  E_control;
  logic [1:0]  W_control;
  logic        mem_control;
  logic        illegal;
  logic [1:0]  count;
`ifdef DECODE_OUT_QUEUE_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_drops;
  logic [15:0] stall_base;
`endif

  int checks   = 0;
  int failures = 0;

  decode_out_queue #(.IR_W(16), .PC_W(16), .DEPTH(2)) dut (
    .clock(clock), .reset(reset), .enable_decode(enable_decode),
    .in_valid(in_valid), .in_ready(in_ready), .ir_in(ir_in), .npc_in(npc_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ir(ir), .npc_out(npc_out), .E_control(E_control), .W_control(W_control),
    .mem_control(mem_control), .illegal(illegal),
`ifdef DECODE_OUT_QUEUE_PERF_EN
    .stall_cycles(stall_cycles), .flush_drops(flush_drops),
`endif
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [15:0] i, input logic [15:0] n);
    in_valid = 1'b1; ir_in = i; npc_in = n;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable_decode = 1'b1; in_valid = 1'b0; ir_in = '0;
    npc_in = '0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ir", ir, 0);
    check("rst_npc", npc_out, 0);
    check("rst_ctrl", {E_control, W_control, mem_control, illegal}, 0);
    reset = 1'b0;
    tick();

    // ADD register form: op2select = ~ir[5] = 1
    push_one(16'h1042, 16'h3001);
    check("add_valid", out_valid, 1);
    check("add_E", E_control, 6'b000001);
    check("add_W", W_control, 2'b00);
    check("add_mem", mem_control, 0);
    check("add_npc", npc_out, 16'h3001);
    check("add_ir", ir, 16'h1042);
    check("add_count", count, 1);
    pop_one();
    check("pop_count0", count, 0);
    check("pop_valid0", out_valid, 0);

    push_one(16'hA201, 16'h3002);
    push_one(16'hE403, 16'h3003);
    check("full_count", count, 2);
    check("full_in_ready", in_ready, 0);
    check("ldi_E", E_control, 6'b000110);
    check("ldi_W", W_control, 2'b10);
    check("ldi_mem", mem_control, 1);
    tick();
    check("stall_hold_ir", ir, 16'hA201);
    check("stall_hold_npc", npc_out, 16'h3002);
    pop_one();
    check("lea_W", W_control, 2'b01);
    check("lea_mem", mem_control, 0);
    check("lea_E", E_control, 6'b000110);
    check("lea_count", count, 1);

    // Second slot now written after wrap; ADD immediate has op2select 0
    push_one(16'h1025, 16'h3004);
    check("wrap_count", count, 2);
    in_valid = 1'b1; ir_in = 16'h5260; npc_in = 16'h3005; out_ready = 1'b1;
    tick();
    check("full_pp_count", count, 1);
    check("full_pp_head", ir, 16'h1025);
    check("addi_E", E_control, 6'b000000);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pp_count", count, 1);
    check("pp_head", ir, 16'h5260);
    check("and_E", E_control, 6'b010000);
    check("pp_npc", npc_out, 16'h3005);
    pop_one();
    check("drain_count", count, 0);

    push_one(16'h967F, 16'h3006);
    check("not_E", E_control, 6'b100000);
    push_one(16'hC1C0, 16'h3007);
    check("pre_flush_count", count, 2);
    flush = 1'b1; in_valid = 1'b1; ir_in = 16'h6000; npc_in = 16'h3008; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
`ifdef DECODE_OUT_QUEUE_PERF_EN
    check("flush_drops", flush_drops, 2);
`endif
    push_one(16'h7000, 16'h3009);
    check("post_flush_ir", ir, 16'h7000);
    check("str_E", E_control, 6'b001000);
    check("str_W", W_control, 2'b00);
    pop_one();

    push_one(16'hF025, 16'h300A);
    check("trap_illegal", illegal, 1);
    check("trap_ctrl", {E_control, W_control, mem_control}, 0);
    enable_decode = 1'b0;
    push_one(16'h2000, 16'h300B);
    enable_decode = 1'b1;
    check("gate_count", count, 1);
    check("gate_head", ir, 16'hF025);
    pop_one();
    pop_one();
    check("empty_pop_count", count, 0);
    push_one(16'h2005, 16'h300C);
    check("ld_ctrl", {E_control, W_control, mem_control, illegal}, {6'b000110, 2'b10, 1'b0, 1'b0});

    push_one(16'hB000, 16'h300D);
`ifdef DECODE_OUT_QUEUE_PERF_EN
    stall_base = stall_cycles;
`endif
    in_valid = 1'b1; ir_in = 16'h0E01;
    repeat (5) tick();
    in_valid = 1'b0;
    check("stall_count", count, 2);
`ifdef DECODE_OUT_QUEUE_PERF_EN
    check("stall_cycles", stall_cycles - stall_base, 5);
`endif
    pop_one();
    check("sti_ctrl", {E_control, W_control, mem_control}, {6'b000110, 2'b00, 1'b1});

    // Asynchronous reset away from any clock edge
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_ir", ir, 0);
    tick();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/decode_out_queue.md
Name: decode_out_queue

Overview:
- Parametrised successor to the decode-stage output bundle: decodes each fetched LC-3 instruction into E_control, W_control and mem_control.
- Holds decoded results in a DEPTH-entry FIFO and presents them to execute with a valid/ready handshake.
- Sits between fetch and execute; adds flush, back-pressure and buffering that the flat decode output bundle lacks.

Parameters:
IR_W, 16, instruction width; opcode is ir_in[IR_W-1 -: 4], mode bit is ir_in[5]
PC_W, 16, width of npc_in/npc_out
DEPTH, 2, FIFO entries (>=1); CNT_W = $clog2(DEPTH+1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable_decode  input  1  push gate; push = in_valid & in_ready & enable_decode
in_valid  input  1  fetch presents ir_in/npc_in
in_ready  output  1  count < DEPTH (combinational from count)
ir_in  input  IR_W  fetched instruction
npc_in  input  PC_W  next PC of that instruction
flush  input  1  discard all queued entries (taken branch)
out_valid  output  1  head entry valid (count != 0)
out_ready  input  1  execute consumes head
ir  output  IR_W  head instruction
npc_out  output  PC_W  head next-PC
E_control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
W_control  output  2  00 ALU, 01 LEA/PC, 10 memory
mem_control  output  1  1 for LDI/STI (indirect)
illegal  output  1  head opcode unsupported (RTI/TRAP/reserved/JSR)
count  output  CNT_W  occupancy

Behaviour:
- Async reset: count=0, read/write pointers=0, out_valid=0, in_ready=1. All entry storage and the outputs derived from it (ir, npc_out, E_control, W_control, mem_control, illegal) read 0.
- Decode is combinational on ir_in and is written into the entry at push, together with ir_in and npc_in.
- Outputs are driven from the head entry, so latency is 1 cycle: push at edge N makes out_valid=1 after edge N.
- Decode table (alu, pcsel1, pcsel2, op2sel / W / mem):
  - ADD 0001: 00,00,0,~ir[5] / 00 / 0
  - AND 0101: 01,00,0,~ir[5] / 00 / 0
  - NOT 1001: 10,00,0,0 / 00 / 0
  - BR 0000: 00,01,1,0 / 00 / 0
  - JMP 1100: 00,11,0,0 / 00 / 0
  - LD 0010: 00,01,1,0 / 10 / 0
  - LDI 1010: 00,01,1,0 / 10 / 1
  - ST 0011: 00,01,1,0 / 00 / 0
  - STI 1011: 00,01,1,0 / 00 / 1
  - LDR 0110: 00,10,0,0 / 10 / 0
  - STR 0111: 00,10,0,0 / 00 / 0
  - LEA 1110: 00,01,1,0 / 01 / 0
  - Others: all controls 0, illegal=1
- Pop = out_valid & out_ready. Pointers wrap modulo DEPTH, including non-power-of-2 DEPTH.
- Push and pop in the same cycle: both occur and count is unchanged. When full, in_ready=0 even if out_ready=1 (no pass-through).
- Pop when empty is ignored. Push attempt with enable_decode=0 is ignored, with no state change.
- flush: next edge sets count=0 and pointers=0; a same-cycle push or pop is discarded. Flush dominates.
- Reset asserted mid-operation: immediate clear, regardless of clock.
- Head outputs stay stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: DECODE_OUT_QUEUE_PERF_EN.
- Defined: adds output stall_cycles [15:0] and output flush_drops [15:0].
  - stall_cycles increments each cycle with in_valid & enable_decode & ~in_ready.
  - flush_drops adds count at each flush.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then push ADD ir_in=16'h1042, npc_in=16'h3001 -> next cycle out_valid=1, E_control=6'b000001, W_control=00, mem_control=0, npc_out=16'h3001.
- DEPTH=2: push LDI 16'hA201 then LEA 16'hE403 with out_ready=0 -> count=2, in_ready=0. Head shows E_control=6'b000110, W=10, mem=1. After one pop, head shows W=01, mem=0.
- Full queue with in_valid=1, out_ready=1 for one cycle -> one pop, no push, count=1. Next cycle pushes, count stays 1.
- count=2, flush=1 with push and pop requested -> count=0, out_valid=0, in_ready=1; the pushed entry never appears.
- Push 16'hF025 (TRAP) -> illegal=1, all controls 0. Push with enable_decode=0 -> count unchanged.
- PERF_EN: hold in_valid=1 against a full queue for 5 cycles -> stall_cycles=5. Flush at count=2 -> flush_drops=2.
